// File: rtl/vram_arb.sv
// VRAM arbiter: interleaves video tile fetches with CPU accesses on a single-port synchronous VRAM.
// Define VRAM_ARB_CPU1_EN to enable the CPU1 port; without it every CPU slot belongs to CPU0.
module vram_arb (
    input  logic       PCLK,
    input  logic       RST_N,
    input  logic [8:0] HPOS,
    input  logic       VBLK,
    input  logic [9:0] VID_AD,
    output logic [7:0] VID_DT,
    output logic       VID_VLD,
    input  logic       C0_REQ,
    input  logic       C0_WE,
    input  logic [9:0] C0_AD,
    input  logic [7:0] C0_DI,
    output logic       C0_ACK,
    output logic [7:0] C0_DO,
    input  logic       C1_REQ,
    input  logic       C1_WE,
    input  logic [9:0] C1_AD,
    input  logic [7:0] C1_DI,
    output logic       C1_ACK,
    output logic [7:0] C1_DO,
    output logic [9:0] RAM_AD,
    output logic       RAM_WE,
    output logic [7:0] RAM_WD,
    input  logic [7:0] RAM_RD
);
    typedef enum logic [1:0] {ACC_NONE, ACC_VID, ACC_CPU0, ACC_CPU1} acc_e;

    acc_e       s1_kind, s2_kind;
    logic       s1_we, s2_we;
    logic       busy0, busy1;
    logic       last_cpu1;
    logic       ack1_q;
    logic [7:0] do1_q;

    logic       c1_req, c1_we;
    logic [9:0] c1_ad;
    logic [7:0] c1_di;
    logic       video_slot, elig0, elig1, grant0, grant1;

`ifdef VRAM_ARB_CPU1_EN
    assign c1_req = C1_REQ;
    assign c1_we  = C1_WE;
    assign c1_ad  = C1_AD;
    assign c1_di  = C1_DI;
    assign C1_ACK = ack1_q;
    assign C1_DO  = do1_q;
`else
    assign c1_req = 1'b0;
    assign c1_we  = 1'b0;
    assign c1_ad  = 10'd0;
    assign c1_di  = 8'd0;
    assign C1_ACK = 1'b0;
    assign C1_DO  = 8'd0;
    logic unused_c1;
    assign unused_c1 = ^{C1_REQ, C1_WE, C1_AD, C1_DI, ack1_q, do1_q};
`endif

    // Even pixels of the active line belong to video; everything else is a CPU slot.
    assign video_slot = !VBLK && (HPOS < 9'd288) && !HPOS[0];
    assign elig0      = C0_REQ && !busy0;
    assign elig1      = c1_req && !busy1;
    assign grant0     = !video_slot && elig0 && (!elig1 || last_cpu1);
    assign grant1     = !video_slot && elig1 && (!elig0 || !last_cpu1);

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            RAM_AD    <= 10'd0;
            RAM_WE    <= 1'b0;
            RAM_WD    <= 8'd0;
            VID_DT    <= 8'd0;
            VID_VLD   <= 1'b0;
            C0_ACK    <= 1'b0;
            C0_DO     <= 8'd0;
            ack1_q    <= 1'b0;
            do1_q     <= 8'd0;
            s1_kind   <= ACC_NONE;
            s2_kind   <= ACC_NONE;
            s1_we     <= 1'b0;
            s2_we     <= 1'b0;
            busy0     <= 1'b0;
            busy1     <= 1'b0;
            last_cpu1 <= 1'b1;
        end else begin
            s2_kind <= s1_kind;
            s2_we   <= s1_we;
            VID_VLD <= 1'b0;
            C0_ACK  <= 1'b0;
            ack1_q  <= 1'b0;

            // RAM_RD now carries the data for the access issued two edges ago.
            case (s2_kind)
                ACC_VID: begin
                    VID_DT  <= RAM_RD;
                    VID_VLD <= 1'b1;
                end
                ACC_CPU0: begin
                    if (!s2_we) C0_DO <= RAM_RD;
                    C0_ACK <= 1'b1;
                    busy0  <= 1'b0;
                end
                ACC_CPU1: begin
                    if (!s2_we) do1_q <= RAM_RD;
                    ack1_q <= 1'b1;
                    busy1  <= 1'b0;
                end
                default: ;
            endcase

            s1_kind <= ACC_NONE;
            s1_we   <= 1'b0;
            RAM_WE  <= 1'b0;
            if (video_slot) begin
                RAM_AD  <= VID_AD;
                s1_kind <= ACC_VID;
            end else if (grant0) begin
                RAM_AD    <= C0_AD;
                RAM_WD    <= C0_DI;
                RAM_WE    <= C0_WE;
                s1_kind   <= ACC_CPU0;
                s1_we     <= C0_WE;
                busy0     <= 1'b1;
                last_cpu1 <= 1'b0;
            end else if (grant1) begin
                RAM_AD    <= c1_ad;
                RAM_WD    <= c1_di;
                RAM_WE    <= c1_we;
                s1_kind   <= ACC_CPU1;
                s1_we     <= c1_we;
                busy1     <= 1'b1;
                last_cpu1 <= 1'b1;
            end
        end
    end
endmodule
